dm_access_ctrl: RTL and testbench

//  Upstream sequencer for the data memory (DM). Accepts one memory op at a time from the core
//  (LOAD/STORE/PUSH/POP/SETSP) and owns the stack pointer. Drives one-cycle DM strobes with

---
 rtl/dm_access_pkg.sv | 35 +++
 rtl/dm_sp_unit.sv | 46 ++++
 rtl/dm_access_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_pkg.sv
// Shared definitions for the data-memory access controller: op codes, FSM states,
// stack-pointer commands and the debug view of the controller.
package dm_access_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] OP_SETSP = 3'd5;

  // Wide enough for DM_LAT-2 with DM_LAT up to 7.
  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SP_HOLD = 2'd0,
    SP_DEC  = 2'd1,
    SP_INC  = 2'd2,
    SP_LOAD = 2'd3
  } sp_cmd_t;

  typedef struct packed {
    state_t state;
    logic   sp_full;
    logic   sp_empty;
  } dbg_t;

endpackage

// File: rtl/dm_sp_unit.sv
// Architectural stack pointer: holds, pre-decrements, post-increments or loads SP and
// reports the full/empty compares used by the controller's guard (STACK_GUARD_EN).
module dm_sp_unit
  import dm_access_pkg::*;
#(
  parameter int             SP_W     = 16,
  parameter logic [SP_W-1:0] SP_TOP   = 16'hFFFF,
  parameter logic [SP_W-1:0] SP_LIMIT = 16'hFE00
) (
  input  logic            clk,
  input  logic            rst_n,
  input  sp_cmd_t         i_cmd,
  input  logic [SP_W-1:0] i_load_val,
  output logic [SP_W-1:0] o_sp_cur,
  output logic [SP_W-1:0] o_sp_dec,
  output logic            o_full,
  output logic            o_empty
);

  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_sp_dec;
  logic [SP_W-1:0] w_sp_inc;

  // Modulo 2^SP_W arithmetic: wrap is intentional when the guard is not built in.
  assign w_sp_dec = r_sp - 1'b1;
  assign w_sp_inc = r_sp + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp <= SP_TOP;
    end else begin
      case (i_cmd)
        SP_DEC:  r_sp <= w_sp_dec;
        SP_INC:  r_sp <= w_sp_inc;
        SP_LOAD: r_sp <= i_load_val;
        default: r_sp <= r_sp;
      endcase
    end
  end

  assign o_sp_cur = r_sp;
  assign o_sp_dec = w_sp_dec;
  assign o_full   = (r_sp == SP_LIMIT);
  assign o_empty  = (r_sp == SP_TOP);

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer: one op at a time, one-cycle DM strobes, read capture.
// Optional stack overflow/underflow rejection is built when STACK_GUARD_EN is defined.
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 9,
  parameter int              SP_W     = 16,
  parameter logic [SP_W-1:0] SP_TOP   = 16'hFFFF,
  parameter logic [SP_W-1:0] SP_LIMIT = 16'hFE00,
  parameter int              DM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_data,
  output logic              load,
  output logic              store,
  output logic              push,
  output logic              pop,
  output logic [ADDR_W-1:0] address,
  output logic [SP_W-1:0]   sp,
  output logic [DATA_W-1:0] rez,
  input  logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [SP_W-1:0]   sp_cur,
  output logic              stack_ovf,
  output logic              stack_unf,
  output dbg_t              dbg
);

  // Handshake: an op transfers on a rising edge where op_valid & op_ready are both high;
  // op_ready is high only in IDLE, so the requester simply holds its op until then.

  localparam logic [LAT_CNT_W-1:0] WAIT_INIT =
    (DM_LAT > 1) ? LAT_CNT_W'(DM_LAT - 2) : '0;

  state_t                r_state;
  logic                  r_is_read;
  logic [LAT_CNT_W-1:0]  r_cnt;
  logic                  r_load, r_store, r_push, r_pop;
  logic [ADDR_W-1:0]     r_address;
  logic [SP_W-1:0]       r_sp;
  logic [DATA_W-1:0]     r_rez;
  logic                  r_rd_valid;
  logic [DATA_W-1:0]     r_rd_data;
  logic                  r_ovf, r_unf;

  logic                  w_accept;
  logic                  w_full, w_empty;
  logic                  w_push_rej, w_pop_rej;
  logic [SP_W-1:0]       w_sp_cur, w_sp_dec;
  sp_cmd_t               w_sp_cmd;

  assign op_ready = (r_state == ST_IDLE);
  assign w_accept = op_valid & op_ready;

`ifdef STACK_GUARD_EN
  assign w_push_rej = (op_code == OP_PUSH) & w_full;
  assign w_pop_rej  = (op_code == OP_POP)  & w_empty;
`else
  assign w_push_rej = 1'b0;
  assign w_pop_rej  = 1'b0;
`endif

  always_comb begin
    w_sp_cmd = SP_HOLD;
    if (w_accept) begin
      case (op_code)
        OP_PUSH:  w_sp_cmd = w_push_rej ? SP_HOLD : SP_DEC;
        OP_POP:   w_sp_cmd = w_pop_rej  ? SP_HOLD : SP_INC;
        OP_SETSP: w_sp_cmd = SP_LOAD;
        default:  w_sp_cmd = SP_HOLD;
      endcase
    end
  end

  dm_sp_unit #(
    .SP_W     (SP_W),
    .SP_TOP   (SP_TOP),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cmd      (w_sp_cmd),
    .i_load_val (op_data[SP_W-1:0]),
    .o_sp_cur   (w_sp_cur),
    .o_sp_dec   (w_sp_dec),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_is_read  <= 1'b0;
      r_cnt      <= '0;
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_push     <= 1'b0;
      r_pop      <= 1'b0;
      r_address  <= '0;
      r_sp       <= '0;
      r_rez      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_push     <= 1'b0;
      r_pop      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (op_code)
              OP_LOAD: begin
                r_address <= op_addr;
                r_load    <= 1'b1;
                r_is_read <= 1'b1;
                r_state   <= ST_ISSUE;
              end
              OP_STORE: begin
                r_address <= op_addr;
                r_rez     <= op_data;
                r_store   <= 1'b1;
                r_is_read <= 1'b0;
                r_state   <= ST_ISSUE;
              end
              OP_PUSH: begin
                if (w_push_rej) begin
                  r_ovf <= 1'b1;
                end else begin
                  r_sp      <= w_sp_dec;
                  r_rez     <= op_data;
                  r_push    <= 1'b1;
                  r_is_read <= 1'b0;
                  r_state   <= ST_ISSUE;
                end
              end
              OP_POP: begin
                if (w_pop_rej) begin
                  r_unf <= 1'b1;
                end else begin
                  r_sp      <= w_sp_cur;
                  r_pop     <= 1'b1;
                  r_is_read <= 1'b1;
                  r_state   <= ST_ISSUE;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_ISSUE: begin
          if (!r_is_read) begin
            r_state <= ST_IDLE;
          end else if (DM_LAT > 1) begin
            r_cnt   <= WAIT_INIT;
            r_state <= ST_WAIT;
          end else begin
            r_state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) r_state <= ST_RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_RESP: begin
          // data_out is valid exactly in this cycle; rd_valid follows one cycle later.
          r_rd_data  <= data_out;
          r_rd_valid <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load      = r_load;
  assign store     = r_store;
  assign push      = r_push;
  assign pop       = r_pop;
  assign address   = r_address;
  assign sp        = r_sp;
  assign rez       = r_rez;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign sp_cur    = w_sp_cur;
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

  assign dbg.state    = r_state;
  assign dbg.sp_full  = w_full;
  assign dbg.sp_empty = w_empty;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed and random ops against a transaction-level
// model, with a behavioural data memory behind the DUT. Honors STACK_GUARD_EN.
module tb_dm_access_ctrl;
  import dm_access_pkg::*;

  localparam int              DATA_W   = 16;
  localparam int              ADDR_W   = 9;
  localparam int              SP_W     = 16;
  localparam logic [SP_W-1:0] SP_TOP   = 16'hFFFF;
  localparam logic [SP_W-1:0] SP_LIMIT = 16'hFE00;
  parameter  int              DM_LAT   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;
  logic              load, store, push, pop;
  logic [ADDR_W-1:0] address;
  logic [SP_W-1:0]   sp;
  logic [DATA_W-1:0] rez;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [SP_W-1:0]   sp_cur;
  logic              stack_ovf, stack_unf;
  dbg_t              dbg;

  dm_access_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_W(SP_W),
    .SP_TOP(SP_TOP), .SP_LIMIT(SP_LIMIT), .DM_LAT(DM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_addr(op_addr), .op_data(op_data),
    .load(load), .store(store), .push(push), .pop(pop),
    .address(address), .sp(sp), .rez(rez), .data_out(data_out),
    .rd_valid(rd_valid), .rd_data(rd_data), .sp_cur(sp_cur),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf), .dbg(dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural data memory ----------------
  logic [DATA_W-1:0] dm_dir [0:511];
  logic [DATA_W-1:0] dm_stk [0:65535];
  logic [DATA_W-1:0] rd_pipe [0:7];

  initial begin
    for (int i = 0; i < 512; i++)   dm_dir[i] = '0;
    for (int i = 0; i < 65536; i++) dm_stk[i] = '0;
  end

  always @(posedge clk) begin
    if (store) dm_dir[address] = rez;
    if (push)  dm_stk[sp]      = rez;
    rd_pipe[0] <= load ? dm_dir[address] : (pop ? dm_stk[sp] : DATA_W'($urandom));
    for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign data_out = rd_pipe[DM_LAT-1];

  // ---------------- reference model + expectation queues ----------------
  typedef struct {
    int          kind;   // 1 load, 2 store, 3 push, 4 pop
    int          cyc;
    logic [15:0] addr;   // address for load/store, sp for push/pop
    logic [15:0] val;    // rez for store/push
  } ev_t;

  ev_t               strb_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                exp_cyc_q[$];
  int                flag_q[$];      // 1 overflow, 2 underflow
  int                flag_cyc_q[$];

  logic [SP_W-1:0]   m_sp;
  logic [DATA_W-1:0] m_dir [int];
  logic [DATA_W-1:0] m_stk [int];

  function automatic logic [DATA_W-1:0] m_read(input bit stack, input int key);
    if (stack) return m_stk.exists(key) ? m_stk[key] : '0;
    return m_dir.exists(key) ? m_dir[key] : '0;
  endfunction

  // Applies one accepted op; returns 1 when it occupies the controller past the accept cycle.
  task automatic model_accept(input logic [2:0] code, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input int c, output bit busy);
    bit guard = 1'b0;
`ifdef STACK_GUARD_EN
    guard = 1'b1;
`endif
    busy = 1'b0;
    case (code)
      3'd1: begin
        strb_q.push_back('{1, c + 1, 16'(a), 16'h0});
        exp_q.push_back(m_read(1'b0, int'(a)));
        exp_cyc_q.push_back(c + DM_LAT + 2);
        busy = 1'b1;
      end
      3'd2: begin
        m_dir[int'(a)] = d;
        strb_q.push_back('{2, c + 1, 16'(a), d});
        busy = 1'b1;
      end
      3'd3: begin
        if (guard && m_sp == SP_LIMIT) begin
          flag_q.push_back(1); flag_cyc_q.push_back(c + 1);
        end else begin
          m_sp = m_sp - 1;
          m_stk[int'(m_sp)] = d;
          strb_q.push_back('{3, c + 1, m_sp, d});
          busy = 1'b1;
        end
      end
      3'd4: begin
        if (guard && m_sp == SP_TOP) begin
          flag_q.push_back(2); flag_cyc_q.push_back(c + 1);
        end else begin
          strb_q.push_back('{4, c + 1, m_sp, 16'h0});
          exp_q.push_back(m_read(1'b1, int'(m_sp)));
          exp_cyc_q.push_back(c + DM_LAT + 2);
          m_sp = m_sp + 1;
          busy = 1'b1;
        end
      end
      3'd5: m_sp = d[SP_W-1:0];
      default: ;
    endcase
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic issue_op(input logic [2:0] code, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    int waitc = 0;
    bit busy;
    op_valid = 1'b1; op_code = code; op_addr = a; op_data = d;
    while (!op_ready) begin
      @(negedge clk);
      waitc++;
      if (waitc > 40) begin
        chk("accept_timeout", 32'(waitc), 32'd40);
        op_valid = 1'b0;
        return;
      end
    end
    model_accept(code, a, d, cyc, busy);
    @(negedge clk);
    chk("sp_cur_after_op", 32'(sp_cur), 32'(m_sp));
    chk("op_ready_after_op", 32'(op_ready), busy ? 32'd0 : 32'd1);
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    int   n, kind;
    ev_t  e;
    if (mon_en) begin
      n = int'(load) + int'(store) + int'(push) + int'(pop);
      if (n > 1) chk("strobe_onehot", 32'(n), 32'd1);
      if (n == 1) begin
        kind = load ? 1 : (store ? 2 : (push ? 3 : 4));
        if (strb_q.size() == 0) begin
          chk("strobe_unexpected", 32'(kind), 32'd0);
        end else begin
          e = strb_q.pop_front();
          chk("strobe_kind", 32'(kind), 32'(e.kind));
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("strobe_addr", (kind <= 2) ? 32'(address) : 32'(sp), 32'(e.addr));
          if (kind == 2 || kind == 3) chk("strobe_rez", 32'(rez), 32'(e.val));
        end
      end else if (strb_q.size() > 0 && strb_q[0].cyc < cyc) begin
        chk("strobe_missing", 32'd0, 32'(strb_q[0].kind));
        void'(strb_q.pop_front());
      end

      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 32'(rd_data), 32'hDEAD_0000);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
          chk("rd_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        chk("rd_missing", 32'd0, 32'(exp_q.pop_front()));
        void'(exp_cyc_q.pop_front());
      end

      if (stack_ovf || stack_unf) begin
        kind = stack_ovf ? 1 : 2;
        if (flag_q.size() == 0) begin
          chk("flag_unexpected", 32'(kind), 32'd0);
        end else begin
          chk("flag_kind", 32'(kind), 32'(flag_q.pop_front()));
          chk("flag_cycle", 32'(cyc), 32'(flag_cyc_q.pop_front()));
        end
      end else if (flag_cyc_q.size() > 0 && flag_cyc_q[0] < cyc) begin
        chk("flag_missing", 32'd0, 32'(flag_q.pop_front()));
        void'(flag_cyc_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  logic [SP_W-1:0] setsp_vals [0:5];

  initial begin
    int r;
    logic [2:0]        code;
    logic [DATA_W-1:0] d;
    setsp_vals[0] = 16'hFFFF; setsp_vals[1] = 16'hFE00; setsp_vals[2] = 16'hFE02;
    setsp_vals[3] = 16'h0000; setsp_vals[4] = 16'hFFFD; setsp_vals[5] = 16'h0001;

    rst_n = 1'b0; op_valid = 1'b0; op_code = '0; op_addr = '0; op_data = '0;
    m_sp = SP_TOP;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {28'd0, load, store, push, pop}, 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_sp_cur", 32'(sp_cur), 32'hFFFF);
    chk("reset_op_ready", 32'(op_ready), 32'd1);
    chk("reset_regs", {address, sp, rez, rd_data} == '0 ? 32'd0 : 32'd1, 32'd0);
    chk("reset_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a LOAD: the read never completes, SP returns to the top.
    issue_op(OP_SETSP, '0, 16'h1234);
    issue_op(OP_LOAD, 9'h055, '0);
    chk("mid_load_strobe", 32'(load), 32'd1);
    op_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("in_reset_quiet", {27'd0, load, store, push, pop, rd_valid}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (DM_LAT + 4) begin
      @(negedge clk);
      chk("post_reset_quiet", {27'd0, load, store, push, pop, rd_valid}, 32'd0);
    end
    chk("post_reset_sp_cur", 32'(sp_cur), 32'hFFFF);
    chk("post_reset_op_ready", 32'(op_ready), 32'd1);
    strb_q.delete(); exp_q.delete(); exp_cyc_q.delete(); flag_q.delete(); flag_cyc_q.delete();
    m_sp = SP_TOP;
    mon_en = 1'b1;

    // Directed traffic.
    issue_op(OP_STORE, 9'h012, 16'hBEEF);
    issue_op(OP_LOAD,  9'h012, '0);
    idle(DM_LAT + 3);
    issue_op(OP_PUSH, '0, 16'h1111);
    issue_op(OP_PUSH, '0, 16'h2222);
    issue_op(OP_POP,  '0, '0);
    issue_op(OP_POP,  '0, '0);
    chk("stack_balanced_sp", 32'(sp_cur), 32'hFFFF);
`ifdef STACK_GUARD_EN
    issue_op(OP_POP,   '0, '0);
    issue_op(OP_SETSP, '0, 16'hFE00);
    issue_op(OP_PUSH,  '0, 16'h5A5A);
    chk("guard_full_sp", 32'(sp_cur), 32'hFE00);
    issue_op(OP_SETSP, '0, 16'hFFFF);
`else
    issue_op(OP_SETSP, '0, 16'h0000);
    issue_op(OP_POP,   '0, '0);
    chk("wrap_pop_sp", 32'(sp_cur), 32'h0001);
    issue_op(OP_SETSP, '0, 16'hFFFF);
    issue_op(OP_PUSH,  '0, 16'h7777);
    chk("push_from_top_sp", 32'(sp_cur), 32'hFFFE);
`endif
    issue_op(OP_NOP, 9'h1FF, 16'hFFFF);
    issue_op(3'd7,   9'h012, 16'h0000);
    idle(DM_LAT + 3);

    // Random traffic, mostly back-to-back with op_valid held high.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 20) code = OP_LOAD;
      else if (r < 40) code = OP_STORE;
      else if (r < 60) code = OP_PUSH;
      else if (r < 80) code = OP_POP;
      else if (r < 88) code = OP_SETSP;
      else if (r < 94) code = OP_NOP;
      else             code = 3'($urandom_range(6, 7));
      d = DATA_W'($urandom);
      if (code == OP_SETSP) d = setsp_vals[$urandom_range(0, 5)];
      issue_op(code, ADDR_W'($urandom_range(0, 15)), d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(DM_LAT + 10);

    chk("drain_strobes", 32'(strb_q.size()), 32'd0);
    chk("drain_reads", 32'(exp_q.size()), 32'd0);
    chk("drain_flags", 32'(flag_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
